ad_sample_ctrl: RTL and testbench

AD_SAMPLE_CTRL -- requirements
Module: ad_sample_ctrl

---
 rtl/ad_sample_ctrl.sv | 128 ++++++++++++
 tb/tb_ad_sample_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad_sample_ctrl.sv
// ad_sample_ctrl: AD9238 capture sequencer feeding a sample FIFO under MAC control.
// Latency: ad_data -> fifo_wr_data is one register stage; all outputs are registered.
// Backpressure: a slot that meets fifo_full is dropped (sticky overflow), so capture length never stretches.
//
// Ports:
//   clk, rst_n            sole rising-edge clock, synchronous active-low reset
//   ad_data               12-bit offset-binary ADC sample, valid every clk
//   ad_sample_req/_ack    4-phase capture handshake with MAC control
//   sample_len            requested sample count, latched when a request is accepted
//   read_req/read_req_ack downstream drain request and its one-cycle acknowledge
//   fifo_wr_en/_wr_data   sample FIFO write port; fifo_full is the FIFO full flag
//   busy, overflow        status: not idle / a sample was dropped this capture
module ad_sample_ctrl #(
  parameter logic [31:0] SAMPLE_MAX    = 32'h00080000,
  parameter int          SETTLE_CYCLES = 16,
  parameter bit          DATA_SIGN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] ad_data,
  input  logic        ad_sample_req,
  output logic        ad_sample_ack,
  input  logic [31:0] sample_len,
  input  logic        read_req,
  output logic        read_req_ack,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  input  logic        fifo_full,
  output logic        busy,
  output logic        overflow
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETTLE    = 3'd1;
  localparam logic [2:0] WAIT_READ = 3'd2;
  localparam logic [2:0] CAPTURE   = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] len;
  logic [31:0] len_clamp;
  logic [31:0] settle_cnt;
  logic [31:0] slot_cnt;
  logic        launch;     // a sample slot is issued at this edge
  logic [15:0] fmt_data;

  assign len_clamp = (sample_len > SAMPLE_MAX) ? SAMPLE_MAX : sample_len;

  // Offset binary becomes two's complement by flipping the MSB.
  always_comb begin
    if (DATA_SIGN) fmt_data = {{4{~ad_data[11]}}, ~ad_data[11], ad_data[10:0]};
    else           fmt_data = {4'h0, ad_data};
  end

  // Dropping the request outside IDLE/DONE is an abort and wins over everything else.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (ad_sample_req) state_nxt = (len_clamp == 32'd0) ? DONE : SETTLE;
      end
      SETTLE: begin
        if (!ad_sample_req)                state_nxt = IDLE;
        else if (settle_cnt == SETTLE_LAST) state_nxt = WAIT_READ;
      end
      WAIT_READ: begin
        if (!ad_sample_req) state_nxt = IDLE;
        else if (read_req) begin
          state_nxt = CAPTURE;
          launch    = 1'b1;
        end
      end
      CAPTURE: begin
        if (!ad_sample_req)       state_nxt = IDLE;
        else if (slot_cnt == len) state_nxt = DONE;
        else                      launch    = 1'b1;
      end
      DONE: begin
        if (!ad_sample_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the
  // state they describe. fifo_full is sampled at the edge that issues the slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      len           <= 32'd0;
      settle_cnt    <= 32'd0;
      slot_cnt      <= 32'd0;
      ad_sample_ack <= 1'b0;
      read_req_ack  <= 1'b0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= 16'h0000;
      busy          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state        <= state_nxt;
      fifo_wr_data <= fmt_data;

      if (state == IDLE && ad_sample_req) begin
        len      <= len_clamp;
        overflow <= 1'b0;
      end

      if (state == SETTLE && state_nxt == SETTLE) settle_cnt <= settle_cnt + 32'd1;
      else                                        settle_cnt <= 32'd0;

      // slot_cnt holds the number of slots issued so far in this capture.
      if (launch)                    slot_cnt <= (state == WAIT_READ) ? 32'd1 : slot_cnt + 32'd1;
      else if (state_nxt != CAPTURE) slot_cnt <= 32'd0;

      fifo_wr_en <= launch && !fifo_full;
      if (launch && fifo_full) overflow <= 1'b1;

      read_req_ack  <= (state == WAIT_READ) && (state_nxt == CAPTURE);
      ad_sample_ack <= (state_nxt == DONE);
      busy          <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ad_sample_ctrl.sv
// tb_ad_sample_ctrl: scoreboarded bench for ad_sample_ctrl (reduced SAMPLE_MAX to keep runs short).
// Latency: expects sample data one clk after ad_data is presented.
// Backpressure: drives fifo_full over chosen slots and expects dropped writes plus overflow.
module tb_ad_sample_ctrl;

  localparam logic [31:0] SMAX   = 32'd64;
  localparam int          SETTLE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ad_data;
  logic        ad_sample_req;
  logic        ad_sample_ack;
  logic [31:0] sample_len;
  logic        read_req;
  logic        read_req_ack;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        fifo_full;
  logic        busy;
  logic        overflow;

  int errs   = 0;
  int checks = 0;

  logic [15:0] exp_q[$];

  ad_sample_ctrl #(
    .SAMPLE_MAX   (SMAX),
    .SETTLE_CYCLES(SETTLE),
    .DATA_SIGN    (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ad_data      (ad_data),
    .ad_sample_req(ad_sample_req),
    .ad_sample_ack(ad_sample_ack),
    .sample_len   (sample_len),
    .read_req     (read_req),
    .read_req_ack (read_req_ack),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample source: directed corner codes with known formatted values, plus a random code.
  initial begin : src_mon
    logic        r;
    logic [15:0] e;
    logic [11:0] v;
    int          n;
    n       = 0;
    ad_data = 12'h000;
    exp_q.push_back(16'hF800);
    forever begin
      @(posedge clk);
      r = rst_n;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
      if (!r)              chk("wr_data_reset", {16'h0, fifo_wr_data}, 32'h0);
      else if (fifo_wr_en) chk("wr_data", {16'h0, fifo_wr_data}, {16'h0, e});
      case (n % 4)
        0:       begin v = 12'h800; e = 16'h0000; end
        1:       begin v = 12'h000; e = 16'hF800; end
        2:       begin v = 12'hFFF; e = 16'h07FF; end
        default: begin
          v = 12'($urandom_range(0, 4095));
          e = v[11] ? {5'b00000, v[10:0]} : {5'b11111, v[10:0]};
        end
      endcase
      ad_data = v;
      exp_q.push_back(e);
      n++;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},  {31'h0, ad_sample_ack}, 32'h0);
    chk({tag, "_rra"},  {31'h0, read_req_ack},  32'h0);
    chk({tag, "_wren"}, {31'h0, fifo_wr_en},    32'h0);
    chk({tag, "_data"}, {16'h0, fifo_wr_data},  32'h0);
    chk({tag, "_busy"}, {31'h0, busy},          32'h0);
    chk({tag, "_ovf"},  {31'h0, overflow},      32'h0);
  endtask

  // Accept a request with read_req already held, wait out settle, return cycles to ack.
  task automatic start_and_wait_rra(input logic [31:0] len, output int n, output int pre_w);
    sample_len    = len;
    ad_sample_req = 1'b1;
    read_req      = 1'b1;
    tick();
    chk("ovf_clear_on_accept", {31'h0, overflow}, 32'h0);
    n     = 0;
    pre_w = 0;
    while (!read_req_ack && n < 200) begin
      if (fifo_wr_en) pre_w++;
      tick();
      n++;
    end
  endtask

  task automatic do_capture(input logic [31:0] len, input int full_from, input int full_n);
    int n, pre_w, w, cyc, k, rra_n;
    int eff;
    eff = (len > SMAX) ? int'(SMAX) : int'(len);
    if (eff == 0) begin
      sample_len    = len;
      ad_sample_req = 1'b1;
      read_req      = 1'b1;
      tick();
      chk("len0_ack_next", {31'h0, ad_sample_ack}, 32'h1);
      chk("len0_busy",     {31'h0, busy},          32'h1);
      rra_n = 0; w = 0;
      for (int i = 0; i < 4; i++) begin
        if (read_req_ack) rra_n++;
        if (fifo_wr_en)   w++;
        tick();
      end
      chk("len0_no_rra",   rra_n, 0);
      chk("len0_no_write", w,     0);
    end else begin
      start_and_wait_rra(len, n, pre_w);
      chk("settle_cycles", n, SETTLE + 1);
      chk("settle_no_wr",  pre_w, 0);
      // read_req stays high through capture: it must be ignored outside WAIT_READ.
      w = 0; cyc = 0; rra_n = 0;
      while (!ad_sample_ack && cyc < eff + 20) begin
        if (fifo_wr_en)   w++;
        if (read_req_ack) rra_n++;
        cyc++;
        k = cyc + 1;
        fifo_full = (k >= full_from) && (k < full_from + full_n);
        tick();
      end
      fifo_full = 1'b0;
      chk("capture_cycles", cyc,   eff);
      chk("writes",         w,     eff - full_n);
      chk("rra_pulses",     rra_n, 1);
      chk("overflow",       {31'h0, overflow}, (full_n > 0) ? 32'h1 : 32'h0);
      chk("done_no_wr",     {31'h0, fifo_wr_en}, 32'h0);
      tick(); tick();
      chk("ack_held",       {31'h0, ad_sample_ack}, 32'h1);
      chk("done_rra_quiet", {31'h0, read_req_ack},  32'h0);
    end
    ad_sample_req = 1'b0;
    read_req      = 1'b0;
    tick();
    chk("ack_falls",  {31'h0, ad_sample_ack}, 32'h0);
    chk("busy_falls", {31'h0, busy},          32'h0);
  endtask

  initial begin : main
    int n, pre_w, w, a;
    rst_n         = 1'b0;
    ad_sample_req = 1'b0;
    read_req      = 1'b0;
    fifo_full     = 1'b0;
    sample_len    = 32'd0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    do_capture(32'd8, 0, 0);
    do_capture(32'd10, 4, 3);
    do_capture(32'd0, 0, 0);
    do_capture(32'hFFFF_FFFF, 0, 0);

    // Abort mid-capture: writes stop on the next cycle and no ack ever appears.
    start_and_wait_rra(32'd20, n, pre_w);
    repeat (4) tick();
    chk("abort_pre_wr", {31'h0, fifo_wr_en}, 32'h1);
    ad_sample_req = 1'b0;
    read_req      = 1'b0;
    tick();
    chk("abort_wr_stop", {31'h0, fifo_wr_en}, 32'h0);
    chk("abort_idle",    {31'h0, busy},       32'h0);
    w = 0; a = 0;
    for (int i = 0; i < 6; i++) begin
      if (fifo_wr_en)    w++;
      if (ad_sample_ack) a++;
      tick();
    end
    chk("abort_no_wr",  w, 0);
    chk("abort_no_ack", a, 0);

    // Reset in the middle of a later capture.
    start_and_wait_rra(32'd20, n, pre_w);
    repeat (3) tick();
    chk("rst_pre_wr", {31'h0, fifo_wr_en}, 32'h1);
    rst_n         = 1'b0;
    ad_sample_req = 1'b0;
    read_req      = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    chk("post_rst_ack",  {31'h0, ad_sample_ack}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
